// File: rtl/quote_ladder.sv
// Multi-level bid/ask quote generator: one request becomes NUM_LEVELS levels,
// each widened by a per-level step and emitted one per valid/ready handshake.
module quote_ladder #(
  parameter int FP_WORD_SIZE = 64,
  parameter int FRAC_BITS    = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_LEVELS   = 4,
  parameter int MIN_PRICE    = 1,
  localparam int LEVEL_W     = $clog2(NUM_LEVELS) + 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [FP_WORD_SIZE-1:0] i_ref_price,
  input  logic [FP_WORD_SIZE-1:0] i_spread,
  input  logic [FP_WORD_SIZE-1:0] i_level_step,
  input  logic                    i_data_valid,
  output logic                    o_ready,
  input  logic                    i_flush,
  input  logic                    i_ready,
  output logic                    o_data_valid,
  output logic [LEVEL_W-1:0]      o_level,
  output logic [DATA_WIDTH-1:0]   o_buy_price,
  output logic [DATA_WIDTH-1:0]   o_ask_price,
  output logic                    o_bid_ok,
  output logic                    o_ask_ok,
  output logic                    o_last,
  output logic [1:0]              o_state
);

  // Handshake: a level transfers on a rising clk edge where o_data_valid and
  // i_ready are both high; o_data_valid never drops and the level fields never
  // change until that edge (or a flush/reset). A request is taken on an edge
  // where i_data_valid and o_ready are both high.

  localparam int INT_W = FP_WORD_SIZE - FRAC_BITS;
  localparam logic [INT_W:0]       DATA_MAX = {{(INT_W + 1 - DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};
  localparam logic [INT_W-1:0]     MIN_INT  = INT_W'(MIN_PRICE);
  localparam logic [LEVEL_W-1:0]   LAST_K   = LEVEL_W'(NUM_LEVELS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t state, state_next;

  logic [FP_WORD_SIZE-1:0] ref_q, off_q, step_q;
  logic [LEVEL_W-1:0]      k_q;
  logic                    sat_q;

  logic [FP_WORD_SIZE:0]   bid_fp, ask_fp, off_sum;
  logic [INT_W-1:0]        bid_int, ask_int;
  logic [INT_W:0]          ask_ceil;
  logic                    bid_low, bid_high, ask_bad;
  logic [DATA_WIDTH-1:0]   buy_calc, ask_calc;

  // One extra bit on each sum exposes the borrow (bid) and carry (ask/offset).
  assign bid_fp   = {1'b0, ref_q} - {1'b0, off_q};
  assign ask_fp   = {1'b0, ref_q} + {1'b0, off_q};
  assign off_sum  = {1'b0, off_q} + {1'b0, step_q};
  assign bid_int  = bid_fp[FP_WORD_SIZE-1:FRAC_BITS];
  assign ask_int  = ask_fp[FP_WORD_SIZE-1:FRAC_BITS];
  assign ask_ceil = {1'b0, ask_int} + {{INT_W{1'b0}}, |ask_fp[FRAC_BITS-1:0]};

  assign bid_low  = bid_fp[FP_WORD_SIZE] || (bid_int < MIN_INT);
  assign bid_high = {1'b0, bid_int} > DATA_MAX;
  assign buy_calc = bid_low ? '0 : (bid_high ? '1 : bid_int[DATA_WIDTH-1:0]);
  assign ask_bad  = ask_fp[FP_WORD_SIZE] || (ask_ceil > DATA_MAX);
  assign ask_calc = ask_bad ? '1 : ask_ceil[DATA_WIDTH-1:0];

  assign o_ready      = (state == IDLE);
  assign o_data_valid = (state == EMIT);
  assign o_state      = state;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_data_valid) state_next = CALC;
      CALC:    state_next = EMIT;
      EMIT:    if (i_ready) state_next = o_last ? IDLE : CALC;
      default: state_next = IDLE;
    endcase
    if (i_flush) state_next = IDLE;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ref_q       <= '0;
      off_q       <= '0;
      step_q      <= '0;
      k_q         <= '0;
      sat_q       <= 1'b0;
      o_level     <= '0;
      o_buy_price <= '0;
      o_ask_price <= '0;
      o_bid_ok    <= 1'b0;
      o_ask_ok    <= 1'b0;
      o_last      <= 1'b0;
    end else if (i_flush) begin
      o_level     <= '0;
      o_buy_price <= '0;
      o_ask_price <= '0;
      o_bid_ok    <= 1'b0;
      o_ask_ok    <= 1'b0;
      o_last      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_data_valid) begin
            ref_q  <= i_ref_price;
            off_q  <= i_spread >> 1;
            step_q <= i_level_step;
            k_q    <= '0;
            sat_q  <= 1'b0;
          end
        end
        CALC: begin
          o_level     <= k_q;
          o_buy_price <= buy_calc;
          o_ask_price <= ask_calc;
          o_bid_ok    <= !bid_low && !bid_high && !sat_q;
          o_ask_ok    <= !ask_bad && !sat_q;
          o_last      <= (k_q == LAST_K);
        end
        EMIT: begin
          if (i_ready) begin
            if (o_last) begin
              o_level     <= '0;
              o_buy_price <= '0;
              o_ask_price <= '0;
              o_bid_ok    <= 1'b0;
              o_ask_ok    <= 1'b0;
              o_last      <= 1'b0;
            end else begin
              // Once the offset has clamped, every later level is flagged illegal.
              k_q   <= k_q + LEVEL_W'(1);
              off_q <= off_sum[FP_WORD_SIZE] ? '1 : off_sum[FP_WORD_SIZE-1:0];
              sat_q <= sat_q | off_sum[FP_WORD_SIZE];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_quote_ladder.sv
// Directed and randomized checks of quote_ladder against an arithmetic model
// of the ladder pricing rules (default parameters).
module tb_quote_ladder;

  localparam int REC_W = 70;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [63:0] i_ref_price, i_spread, i_level_step;
  logic        i_data_valid, i_flush, i_ready;
  logic        o_ready, o_data_valid;
  logic [2:0]  o_level;
  logic [31:0] o_buy_price, o_ask_price;
  logic        o_bid_ok, o_ask_ok, o_last;
  logic [1:0]  o_state;

  int checks = 0;
  int failures = 0;
  logic [REC_W-1:0] exp_q[$];

  quote_ladder dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_ref_price(i_ref_price), .i_spread(i_spread), .i_level_step(i_level_step),
    .i_data_valid(i_data_valid), .o_ready(o_ready), .i_flush(i_flush), .i_ready(i_ready),
    .o_data_valid(o_data_valid), .o_level(o_level),
    .o_buy_price(o_buy_price), .o_ask_price(o_ask_price),
    .o_bid_ok(o_bid_ok), .o_ask_ok(o_ask_ok), .o_last(o_last), .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [REC_W-1:0] rec();
    return {o_level, o_buy_price, o_ask_price, o_bid_ok, o_ask_ok, o_last};
  endfunction

  // Pricing straight from the rules, in 128-bit integer arithmetic:
  // off = spread/2 + k*step clamped to 2^64-1; bid = floor(ref-off); ask = ceil(ref+off).
  function automatic logic [REC_W-1:0] model_level(input logic [63:0] r, input logic [63:0] sp,
                                                   input logic [63:0] st, input int k);
    logic [127:0] max64, max32, one_tick, off, bint, ceil_v;
    logic [31:0]  buy, ask;
    bit           sat, bok, aok;
    max64    = {64'd0, {64{1'b1}}};
    max32    = {96'd0, {32{1'b1}}};
    one_tick = 128'd1 << 32;
    off = ({64'd0, sp} >> 1) + 128'(k) * {64'd0, st};
    sat = off > max64;
    if (sat) off = max64;
    if (off > {64'd0, r}) begin
      buy = '0; bok = 0;
    end else begin
      bint = ({64'd0, r} - off) / one_tick;
      if (bint < 128'd1) begin buy = '0; bok = 0; end
      else begin buy = bint[31:0]; bok = 1; end
    end
    ceil_v = ({64'd0, r} + off + one_tick - 128'd1) / one_tick;
    if (ceil_v > max32) begin ask = '1; aok = 0; end
    else begin ask = ceil_v[31:0]; aok = 1; end
    if (sat) begin bok = 0; aok = 0; end
    return {3'(k), buy, ask, bok, aok, (k == 3)};
  endfunction

  // Called on a negedge with the block idle; returns on the negedge after the accept.
  task automatic send_req(input logic [63:0] r, input logic [63:0] sp, input logic [63:0] st);
    check("ready_before_req", o_ready, 1'b1);
    i_ref_price  = r;
    i_spread     = sp;
    i_level_step = st;
    i_data_valid = 1'b1;
    @(negedge i_clk);
    i_data_valid = 1'b0;
    for (int k = 0; k < 4; k++) exp_q.push_back(model_level(r, sp, st, k));
  endtask

  task automatic wait_valid();
    int waited;
    waited = 0;
    while (!o_data_valid && waited < 20) begin
      @(negedge i_clk);
      waited++;
    end
  endtask

  // Collects n levels; optionally stalls one level and keeps junk requests asserted.
  task automatic collect(input int n, input int stall_level, input int stall_cycles, input bit junk);
    logic [REC_W-1:0] exp;
    if (junk) begin
      i_data_valid = 1'b1;
      i_ref_price  = {$urandom, $urandom};
      i_spread     = {$urandom, $urandom};
      i_level_step = {$urandom, $urandom};
    end
    for (int i = 0; i < n; i++) begin
      wait_valid();
      if (!o_data_valid || exp_q.size() == 0) begin
        check("valid_timeout", {o_data_valid, 1'b0}, {1'b1, exp_q.size() == 0});
        exp_q.delete();
        i_data_valid = 1'b0;
        return;
      end
      exp = exp_q.pop_front();
      check($sformatf("level%0d", i), rec(), exp);
      if (i == stall_level) begin
        i_ready = 1'b0;
        repeat (stall_cycles) begin
          @(negedge i_clk);
          check("stall_valid", o_data_valid, 1'b1);
          check("stall_hold", rec(), exp);
        end
        i_ready = 1'b1;
      end
      @(negedge i_clk);
    end
    if (junk) i_data_valid = 1'b0;
  endtask

  logic [63:0]      r, sp, st;
  logic [REC_W-1:0] e;
  bit               seen;
  int               mode;

  initial begin
    i_rst = 1'b1;
    i_ref_price = '0; i_spread = '0; i_level_step = '0;
    i_data_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
    repeat (2) @(negedge i_clk);
    check("reset_ready", o_ready, 1'b1);
    check("reset_valid", o_data_valid, 1'b0);
    check("reset_fields", rec(), '0);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("post_reset_ready", o_ready, 1'b1);

    // Ladder values and first-level latency.
    send_req(64'h64_8000_0000, 64'h1_0000_0000, 64'h4000_0000);
    check("lat_cycle1_valid", o_data_valid, 1'b0);
    check("lat_cycle1_ready", o_ready, 1'b0);
    @(negedge i_clk);
    check("lat_cycle2_valid", o_data_valid, 1'b1);
    collect(4, -1, 0, 1'b1);
    check("idle_after_last", o_ready, 1'b1);
    check("no_valid_after_last", o_data_valid, 1'b0);

    // Bid underflow.
    send_req(64'h1_0000_0000, 64'h4_0000_0000, 64'h0);
    collect(4, -1, 0, 1'b0);

    // Ask saturation.
    send_req(64'hFFFF_FFFF_0000_0000, 64'h2_0000_0000, 64'h1_0000_0000);
    collect(4, -1, 0, 1'b0);

    // Backpressure at level 1.
    send_req(64'h64_8000_0000, 64'h1_0000_0000, 64'h4000_0000);
    collect(4, 1, 5, 1'b0);
    check("bp_idle", o_ready, 1'b1);

    // Flush while level 2 waits, then a fresh ladder from k=0.
    send_req(64'h64_8000_0000, 64'h1_0000_0000, 64'h4000_0000);
    collect(2, -1, 0, 1'b0);
    wait_valid();
    i_ready = 1'b0;
    e = exp_q.pop_front();
    check("flush_pre_level", rec(), e);
    i_flush = 1'b1;
    @(negedge i_clk);
    i_flush = 1'b0;
    i_ready = 1'b1;
    check("flush_valid", o_data_valid, 1'b0);
    check("flush_ready", o_ready, 1'b1);
    exp_q.delete();
    send_req(64'h64_8000_0000, 64'h1_0000_0000, 64'h4000_0000);
    collect(4, -1, 0, 1'b0);

    // Randomized ladders across the pricing regimes.
    for (int t = 0; t < 12; t++) begin
      mode = $urandom_range(0, 3);
      case (mode)
        0: begin
          r  = {32'($urandom_range(1000, 32'h3FFF_FFFF)), $urandom};
          sp = {32'($urandom_range(0, 64)), $urandom};
          st = {32'($urandom_range(0, 8)), $urandom};
        end
        1: begin
          r  = {32'($urandom_range(0, 5)), $urandom};
          sp = {32'($urandom_range(0, 10)), $urandom};
          st = {32'($urandom_range(0, 2)), $urandom};
        end
        2: begin
          r  = {32'hFFFF_FFFF - 32'($urandom_range(0, 5)), $urandom};
          sp = {32'($urandom_range(0, 6)), $urandom};
          st = {32'($urandom_range(0, 2)), $urandom};
        end
        default: begin
          r  = {$urandom, $urandom};
          sp = {$urandom, $urandom};
          st = {$urandom | 32'h8000_0000, $urandom};
        end
      endcase
      send_req(r, sp, st);
      collect(4, $urandom_range(0, 4), $urandom_range(1, 3), 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset mid-CALC with a request pending during busy.
    send_req(64'h64_8000_0000, 64'h1_0000_0000, 64'h4000_0000);
    i_data_valid = 1'b1;
    i_ref_price  = 64'h10_0000_0000;
    #2;
    i_rst = 1'b1;
    #1;
    check("async_rst_ready", o_ready, 1'b1);
    check("async_rst_valid", o_data_valid, 1'b0);
    check("async_rst_fields", rec(), '0);
    @(negedge i_clk);
    i_data_valid = 1'b0;
    i_rst = 1'b0;
    exp_q.delete();
    seen = 0;
    repeat (12) begin
      @(negedge i_clk);
      if (o_data_valid) seen = 1;
    end
    check("no_emit_after_reset", seen, 1'b0);
    check("idle_after_reset", o_ready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
